// File: rtl/bcd_serial_subtractor_if.sv
// rtl/bcd_serial_subtractor_if.sv - start/busy/done operand and result bundle for the BCD subtractor
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  borrow_in;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow_out;
  logic                  invalid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a, b, borrow_in,
    input  diff, borrow_out, invalid, busy, done
  );

  modport slave (
    input  start, a, b, borrow_in,
    output diff, borrow_out, invalid, busy, done
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial packed BCD subtractor, LSD first, one digit per clock
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  bcd_serial_subtractor_if.slave       bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           br_q;
  logic           inv_q;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   diff_q;
  logic           borrow_q;
  logic           invalid_q;
  logic           busy_q;
  logic           done_q;

  logic           capture;
  logic           step;
  logic           last;
  logic [3:0]     a_d;
  logic [3:0]     b_d;
  logic [4:0]     t;
  logic [4:0]     t_adj;
  logic [3:0]     digit;
  logic           br_next;
  logic           inv_next;
  logic [W-1:0]   res_next;

  // One digit slice: the 5-bit difference's sign bit doubles as the outgoing borrow.
  always_comb begin
    a_d      = a_q[3:0];
    b_d      = b_q[3:0];
    t        = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, br_q};
    t_adj    = t + 5'd10;
    digit    = t[3:0];
    br_next  = 1'b0;
    if (t[4]) begin
      digit   = t_adj[3:0];
      br_next = 1'b1;
    end
    inv_next = inv_q | (a_d > 4'd9) | (b_d > 4'd9);
    res_next = (res_q >> 4) | (W'(digit) << (W - 4));
    last     = (cnt == CW'(DIGITS - 1));
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      br_q      <= 1'b0;
      inv_q     <= 1'b0;
      cnt       <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state_next == DONE);
      if (capture) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        br_q  <= bus.borrow_in;
        inv_q <= 1'b0;
        res_q <= '0;
        cnt   <= '0;
      end else if (step) begin
        // Operands shift down so the active digit is always at [3:0].
        a_q   <= a_q >> 4;
        b_q   <= b_q >> 4;
        br_q  <= br_next;
        inv_q <= inv_next;
        res_q <= res_next;
        cnt   <= cnt + CW'(1);
        if (last) begin
          diff_q    <= res_next;
          borrow_q  <= br_next;
          invalid_q <= inv_next;
        end
      end
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.invalid    = invalid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
